// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: shares one pipelined single-precision FP adder between
// NREQ requesters. A round-robin arbiter picks one request per cycle and
// registers its operands into the adder. A tag shift register that matches
// the adder depth carries the owner ID, so each sum comes back labelled.
// Per-requester credit counters cap how many operations each requester
// may have in flight.
//
// Handshake: req_valid[i] is the requester's offer and req_ready[i] is the
// grant. An operation is accepted in any cycle where both are high.
// req_ready is combinational, one-hot or zero, and never looks at the
// operand or req_sub inputs. Responses cannot be stalled: resp_valid is high
// for exactly one cycle per accepted operation, and results return in
// acceptance order.
module fp_add_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int FPU_LAT = 5,
    parameter int MAX_OUT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_en,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ-1:0]     req_sub,
    output logic [31:0]         fpu_a,
    output logic [31:0]         fpu_b,
    input  logic [31:0]         fpu_sum,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [31:0]         resp_sum,
    output logic                busy
);

    // One tag entry per adder stage, plus the operand register stage.
    localparam int TDEPTH = FPU_LAT + 1;
    localparam int CW     = $clog2(MAX_OUT + 1);

    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    // Arbitration state
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    count [NREQ];

    // Tag pipe: valid bit and owner ID for each stage in flight
    logic [TDEPTH-1:0] tag_valid;
    logic [IDW-1:0]    tag_id [TDEPTH];

    // Combinational arbitration results
    logic [NREQ-1:0]  resp_hit;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic             hs;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   cand;

    // Selected operands of the granted requester
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_sub;

    // The last tag stage is the response; mark which requester gets a credit back
    always_comb begin
        resp_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_hit[i] = tag_valid[TDEPTH-1] && (tag_id[TDEPTH-1] == IDW'(i));
        end
    end

    // Eligibility: valid request, issue enabled, and a credit is available.
    // A credit returned in this same cycle counts as available, so a
    // requester at its limit can issue in the cycle its oldest result returns.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && issue_en &&
                          ((count[i] < MAX_CNT) || resp_hit[i]);
        end
    end

    // Round-robin search starting at ptr, wrapping modulo NREQ
    always_comb begin
        grant    = '0;
        hs       = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDW'((int'(ptr) + off) % NREQ);
            if (!hs && eligible[cand]) begin
                grant[cand] = 1'b1;
                hs          = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign req_ready = grant;

    // Operand mux for the granted requester; subtract flips the sign of b
    always_comb begin
        sel_a   = req_a[32*int'(grant_id) +: 32];
        sel_b   = req_b[32*int'(grant_id) +: 32];
        sel_sub = req_sub[grant_id];
    end

    // Operand registers: the granted operands, or a zero bubble when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_a <= '0;
            fpu_b <= '0;
        end else if (hs) begin
            fpu_a <= sel_a;
            fpu_b <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
        end else begin
            fpu_a <= '0;
            fpu_b <= '0;
        end
    end

    // Round-robin pointer moves just past the requester that was served
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
        end
    end

    // Tag pipe shifts every cycle; idle slots carry valid=0 and id=0
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            for (int k = 0; k < TDEPTH; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[TDEPTH-2:0], hs};
            tag_id[0] <= hs ? grant_id : '0;
            for (int k = 1; k < TDEPTH; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Credit counters: +1 on issue, -1 on return, unchanged when both happen
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                count[i] <= '0;
            end else if (grant[i] && !resp_hit[i]) begin
                count[i] <= count[i] + CW'(1);
            end else if (resp_hit[i] && !grant[i]) begin
                count[i] <= count[i] - CW'(1);
            end
        end
    end

    assign resp_valid = tag_valid[TDEPTH-1];
    assign resp_id    = tag_id[TDEPTH-1];
    assign resp_sum   = fpu_sum;
    assign busy       = (|tag_valid) || hs;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a 5-stage behavioural adder and an
// expected-response queue checked on every resp_valid.
module tb_fp_add_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int FPU_LAT = 5;
    localparam int MAX_OUT = 3;
    localparam int RESP_LAT = FPU_LAT + 1;
    localparam int W = 32 + IDW + 32;

    logic               clk;
    logic               reset;
    logic               issue_en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_sub;
    logic [31:0]        fpu_a;
    logic [31:0]        fpu_b;
    logic [31:0]        fpu_sum;
    logic               resp_valid;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_sum;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rec;
    logic [31:0]  fpu_pipe [FPU_LAT];
    logic [31:0]  rr_a   [NREQ];
    logic [31:0]  rr_sum [NREQ];

    fp_add_scheduler #(
        .NREQ(NREQ), .IDW(IDW), .FPU_LAT(FPU_LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset), .issue_en(issue_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sum(fpu_sum),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FP helpers (normal numbers and zero) ----------------
    function automatic real sp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return real_to_sp(sp_to_real(a) + sp_to_real(b));
    endfunction

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub);
        return fadd(a, {b[31] ^ sub, b[30:0]});
    endfunction

    // Behavioural adder: FPU_LAT register stages after the operand registers
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FPU_LAT; k++) fpu_pipe[k] <= '0;
        end else begin
            fpu_pipe[0] <= fadd(fpu_a, fpu_b);
            for (int k = 1; k < FPU_LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
        end
    end
    assign fpu_sum = fpu_pipe[FPU_LAT-1];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on each response, push on each handshake
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    rec = exp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(rec[W-1 -: 32]));
                    check("resp_id_sb", 64'(resp_id), 64'(rec[IDW+31:32]));
                    check("resp_sum_sb", 64'(resp_sum), 64'(rec[31:0]));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({32'(cyc + RESP_LAT), IDW'(i),
                                     model_sum(req_a[32*i +: 32], req_b[32*i +: 32], req_sub[i])});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic sub);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = sub;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rr_a[0] = 32'h3F800000; rr_sum[0] = 32'h40000000;
        rr_a[1] = 32'h40000000; rr_sum[1] = 32'h40400000;
        rr_a[2] = 32'h40400000; rr_sum[2] = 32'h40800000;
        rr_a[3] = 32'h40800000; rr_sum[3] = 32'h40A00000;

        reset = 1'b1; issue_en = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0; req_sub = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_fpu_a", 64'(fpu_a), 64'h0);
        check("rst_fpu_b", 64'(fpu_b), 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_id", 64'(resp_id), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        // Single op: 1.0 + 2.0 from req0
        tick();
        issue_en = 1'b1;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'h1);
        check("single_busy", 64'(busy), 64'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_fpu_a", 64'(fpu_a), 64'h3F800000);
        check("single_fpu_b", 64'(fpu_b), 64'h40000000);
        repeat (4) tick();
        @(negedge clk);
        check("single_early", 64'(resp_valid), 64'h0);
        tick();
        @(negedge clk);
        check("single_valid", 64'(resp_valid), 64'h1);
        check("single_id", 64'(resp_id), 64'h0);
        check("single_sum", 64'(resp_sum), 64'h40400000);
        tick();
        @(negedge clk);
        check("single_late", 64'(resp_valid), 64'h0);
        check("single_idle_busy", 64'(busy), 64'h0);

        // Subtract, then an exact-zero subtract, from req2 back to back
        tick();
        set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
        req_valid = 4'b0100;
        @(negedge clk);
        check("sub_ready0", 64'(req_ready), 64'h4);
        tick();
        set_req(2, 32'h3F800000, 32'h3F800000, 1'b1);
        @(negedge clk);
        check("sub_ready1", 64'(req_ready), 64'h4);
        check("sub_fpu_a", 64'(fpu_a), 64'h40400000);
        check("sub_fpu_b", 64'(fpu_b), 64'hBF800000);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("zero_fpu_a", 64'(fpu_a), 64'h3F800000);
        check("zero_fpu_b", 64'(fpu_b), 64'hBF800000);
        repeat (4) tick();
        @(negedge clk);
        check("sub_valid", 64'(resp_valid), 64'h1);
        check("sub_id", 64'(resp_id), 64'h2);
        check("sub_sum", 64'(resp_sum), 64'h40000000);
        tick();
        @(negedge clk);
        check("zero_valid", 64'(resp_valid), 64'h1);
        check("zero_id", 64'(resp_id), 64'h2);
        check("zero_sum", 64'(resp_sum), 64'h0);

        // Serve req3 once so the pointer wraps to 0
        tick();
        set_req(3, 32'h3F800000, 32'h3F800000, 1'b0);
        req_valid = 4'b1000;
        @(negedge clk);
        check("wrap_ready", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, rr_a[i], 32'h3F800000, 1'b0);
        tick();

        // Round-robin: all requesters valid for 8 cycles
        for (int j = 0; j < 14; j++) begin
            req_valid = (j < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (j < 8) check("rr_ready", 64'(req_ready), 64'(4'b0001 << (j % 4)));
            if (j >= 6) begin
                check("rr_resp_valid", 64'(resp_valid), 64'h1);
                check("rr_resp_id", 64'(resp_id), 64'((j - 6) % 4));
                check("rr_resp_sum", 64'(resp_sum), 64'(rr_sum[(j - 6) % 4]));
            end
            tick();
        end

        // Credit limit: req1 alone for 10 cycles
        set_req(1, 32'h40000000, 32'h40000000, 1'b0);
        for (int j = 0; j < 10; j++) begin
            req_valid = 4'b0010;
            @(negedge clk);
            check("credit_ready", 64'(req_ready),
                  ((j < 3) || (j >= 6 && j < 9)) ? 64'h2 : 64'h0);
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // issue_en drop after two grants
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
        for (int j = 0; j < 10; j++) begin
            req_valid = 4'b0011;
            issue_en  = (j < 2);
            @(negedge clk);
            check("ien_ready", 64'(req_ready), (j == 0) ? 64'h1 : (j == 1) ? 64'h2 : 64'h0);
            if (j == 3) check("ien_busy", 64'(busy), 64'h1);
            if (j == 6) begin
                check("ien_resp0_valid", 64'(resp_valid), 64'h1);
                check("ien_resp0_id", 64'(resp_id), 64'h0);
            end
            if (j == 7) begin
                check("ien_resp1_valid", 64'(resp_valid), 64'h1);
                check("ien_resp1_id", 64'(resp_id), 64'h1);
            end
            if (j == 8) check("ien_drained", 64'(busy), 64'h0);
            tick();
        end
        req_valid = '0;
        issue_en  = 1'b1;

        // Reset while three operations are in flight
        set_req(2, 32'h40400000, 32'h3F800000, 1'b0);
        for (int j = 0; j < 3; j++) begin
            req_valid = 4'b0111;
            @(negedge clk);
            check("rst_mid_ready", 64'(req_ready), (j == 0) ? 64'h4 : (j == 1) ? 64'h1 : 64'h2);
            tick();
        end
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("rst_mid_no_resp", 64'(resp_valid), 64'h0);
            if (j == 9) check("rst_mid_busy", 64'(busy), 64'h0);
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk);
        check("rst_mid_first_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (8) tick();
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
